// File: rtl/if_id_queue.sv
// Two-entry skid queue between instruction fetch and decode.
// Presents a bubble ({0, NOP}) to decode whenever the queue is empty.
module if_id_queue #(
  parameter logic [31:0] NOP = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_pc4,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc4,
  output logic [31:0] out_instr,
  output logic [1:0]  count,
  output logic [15:0] bubble_count
);

  logic [31:0] r_pc4   [2];
  logic [31:0] r_instr [2];
  logic        r_wrPtr;
  logic        r_rdPtr;
  logic [1:0]  r_count;
  logic [15:0] r_bubbleCount;

  logic w_push;
  logic w_pop;

  // Handshake decodes use registered occupancy only, so in_ready never
  // depends combinationally on out_ready or flush.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  assign out_pc4      = out_valid ? r_pc4[r_rdPtr]   : 32'h00000000;
  assign out_instr    = out_valid ? r_instr[r_rdPtr] : NOP;
  assign count        = r_count;
  assign bubble_count = r_bubbleCount;

  // Storage is deliberately left out of reset; visibility is gated by count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pc4[r_wrPtr]   <= in_pc4;
      r_instr[r_wrPtr] <= in_instr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (w_pop && !w_push) r_count <= r_count - 2'd1;
    end
  end

  // Saturating count of cycles in which decode saw a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bubbleCount <= 16'h0000;
    end else if (!out_valid && (r_bubbleCount != 16'hFFFF)) begin
      r_bubbleCount <= r_bubbleCount + 16'h0001;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_if_id_queue;

  localparam logic [31:0] NOP = 32'h00000000;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc4;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
  logic [1:0]  count;
  logic [15:0] bubble_count;

  int total = 0;
  int bad   = 0;

  logic [63:0] mQueue [$];
  int          mBubble = 0;

  if_id_queue #(.NOP(NOP)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_pc4(in_pc4), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_pc4(out_pc4), .out_instr(out_instr),
    .count(count), .bubble_count(bubble_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock, applying the queue rules to the model first.
  task automatic tick();
    bit doPop, doPush;
    if (reset) begin
      mQueue.delete();
      mBubble = 0;
    end else begin
      if (mQueue.size() == 0 && mBubble < 65535) mBubble++;
      if (flush) begin
        mQueue.delete();
      end else begin
        doPop  = (mQueue.size() != 0) && out_ready;
        doPush = in_valid && (mQueue.size() < 2);
        if (doPop)  void'(mQueue.pop_front());
        if (doPush) mQueue.push_back({in_pc4, in_instr});
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    reset = 0; in_valid = 0; flush = 0; out_ready = 0;
    in_pc4 = '0; in_instr = '0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    in_valid = 1; out_ready = 1; flush = 1; in_pc4 = 32'd44; in_instr = 32'hDEADBEEF;
    reset = 1;
    tick();
    idleInputs();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (out_pc4 !== 32'd0) begin bad++; $display("[TB] FAIL reset_out_pc4 got=%h exp=0", out_pc4); end
    total++; if (out_instr !== NOP) begin bad++; $display("[TB] FAIL reset_out_instr got=%h exp=%h", out_instr, NOP); end
    total++; if (count !== 2'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    total++; if (bubble_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_bubble got=%0d exp=0", bubble_count); end
  endtask

  task automatic test_single();
    doReset();
    in_valid = 1; in_pc4 = 32'd4; in_instr = 32'h20080001; out_ready = 0;
    tick();
    idleInputs();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%0b exp=1", out_valid); end
    total++; if (out_pc4 !== 32'd4) begin bad++; $display("[TB] FAIL single_pc4 got=%0d exp=4", out_pc4); end
    total++; if (out_instr !== 32'h20080001) begin bad++; $display("[TB] FAIL single_instr got=%h exp=20080001", out_instr); end
    total++; if (count !== 2'd1) begin bad++; $display("[TB] FAIL single_count got=%0d exp=1", count); end
  endtask

  task automatic test_fill();
    doReset();
    in_valid = 1; in_pc4 = 32'd100; in_instr = 32'hAAAA0001; tick();
    in_pc4 = 32'd104; in_instr = 32'hBBBB0002; tick();
    in_pc4 = 32'd108; in_instr = 32'hCCCC0003; tick();
    total++; if (count !== 2'd2) begin bad++; $display("[TB] FAIL fill_count got=%0d exp=2", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_in_ready got=%0b exp=0", in_ready); end
    total++; if (out_instr !== 32'hAAAA0001) begin bad++; $display("[TB] FAIL fill_head got=%h exp=aaaa0001", out_instr); end
    in_valid = 0; out_ready = 1;
    tick();
    total++; if (out_instr !== 32'hBBBB0002 || count !== 2'd1 || in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL fill_pop1 got=%h/%0d/%0b exp=bbbb0002/1/1", out_instr, count, in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || out_instr !== NOP || out_pc4 !== 32'd0) begin
      bad++; $display("[TB] FAIL fill_pop2 got=%0b/%h/%0d exp=0/%h/0", out_valid, out_instr, out_pc4, NOP); end
    idleInputs();
  endtask

  task automatic test_back_to_back();
    doReset();
    in_valid = 1; in_pc4 = 32'd4; in_instr = 32'h1000_0004;
    tick();
    out_ready = 1;
    for (int i = 2; i <= 20; i++) begin
      in_pc4 = 32'(4 * i); in_instr = 32'h1000_0000 + 32'(4 * i);
      tick();
      total++; if (count !== 2'd1 || out_pc4 !== 32'(4 * i) || out_instr !== 32'h1000_0000 + 32'(4 * i)) begin
        bad++; $display("[TB] FAIL stream_lag i=%0d got=%0d/%0d exp=1/%0d", i, count, out_pc4, 4 * i); end
    end
    idleInputs();
  endtask

  task automatic test_flush();
    doReset();
    in_valid = 1; in_pc4 = 32'd8; in_instr = 32'h11110001; tick();
    in_pc4 = 32'd12; in_instr = 32'h22220002; tick();
    in_pc4 = 32'd16; in_instr = 32'h33330003; out_ready = 1; flush = 1;
    tick();
    total++; if (count !== 2'd0 || out_valid !== 1'b0 || out_instr !== NOP || out_pc4 !== 32'd0) begin
      bad++; $display("[TB] FAIL flush_collision got=%0d/%0b/%h/%0d exp=0/0/%h/0", count, out_valid, out_instr, out_pc4, NOP); end
    for (int i = 0; i < 4; i++) begin
      in_pc4 = 32'(20 + 4 * i); in_instr = 32'h44440000 + 32'(i);
      tick();
      total++; if (count !== 2'd0 || out_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL flush_held cyc=%0d got=%0d/%0b exp=0/0", i, count, out_valid); end
    end
    flush = 0; in_valid = 0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_no_leak got=%0b exp=0", out_valid); end
    idleInputs();
  endtask

  task automatic test_reset_mid();
    doReset();
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1; in_pc4 = 32'd4; in_instr = 32'h55550001; tick();
    in_pc4 = 32'd8; in_instr = 32'h55550002; tick();
    total++; if (count !== 2'd2 || bubble_count !== 16'd5) begin
      bad++; $display("[TB] FAIL resetmid_pre got=%0d/%0d exp=2/5", count, bubble_count); end
    out_ready = 1; flush = 1; reset = 1;
    tick();
    idleInputs();
    total++; if (count !== 2'd0 || bubble_count !== 16'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL resetmid_post got=%0d/%0d/%0b/%0b exp=0/0/1/0", count, bubble_count, in_ready, out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] expPc4, expInstr;
    doReset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_pc4    = $urandom;
      in_instr  = $urandom;
      tick();
      expPc4   = (mQueue.size() != 0) ? mQueue[0][63:32] : 32'd0;
      expInstr = (mQueue.size() != 0) ? mQueue[0][31:0]  : NOP;
      total++; if (count !== 2'(mQueue.size()) || out_valid !== (mQueue.size() != 0) ||
                   in_ready !== (mQueue.size() != 2) || out_pc4 !== expPc4 ||
                   out_instr !== expInstr || bubble_count !== 16'(mBubble)) begin
        bad++;
        $display("[TB] FAIL random cyc=%0d got cnt=%0d pc4=%h ins=%h bub=%0d exp cnt=%0d pc4=%h ins=%h bub=%0d",
                 i, count, out_pc4, out_instr, bubble_count, mQueue.size(), expPc4, expInstr, mBubble);
      end
    end
    idleInputs();
  endtask

  task automatic test_saturation();
    doReset();
    for (int i = 0; i < 65534; i++) tick();
    total++; if (bubble_count !== 16'hFFFE) begin bad++; $display("[TB] FAIL sat_pre got=%h exp=fffe", bubble_count); end
    for (int i = 0; i < 70000 - 65534; i++) tick();
    total++; if (bubble_count !== 16'hFFFF || bubble_count !== 16'(mBubble)) begin
      bad++; $display("[TB] FAIL sat_hold got=%h exp=ffff", bubble_count); end
  endtask

  initial begin
    idleInputs();
    @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
